// File: rtl/wb_bus_arbiter.sv
// Writeback bus arbiter: three per-source completion FIFOs drained round-robin,
// one registered beat per cycle onto the shared result bus.
module wb_bus_arbiter #(
    parameter int DEPTH   = 4,
    parameter int PTR_W   = 2,
    parameter int ENTRY_W = 4
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               rdy_in,
    input  logic               flush_in,
    input  logic               alu_valid_in,
    input  logic [31:0]        alu_result_in,
    input  logic [31:0]        alu_pc_in,
    input  logic [ENTRY_W-1:0] alu_entry_in,
    input  logic               ld_valid_in,
    input  logic [31:0]        ld_result_in,
    input  logic [ENTRY_W-1:0] ld_entry_in,
    input  logic               st_valid_in,
    input  logic [ENTRY_W-1:0] st_entry_in,
    output logic               alu_full_out,
    output logic               ld_full_out,
    output logic               st_full_out,
    output logic               wb_valid_out,
    output logic [1:0]         wb_src_out,
    output logic [31:0]        wb_result_out,
    output logic [31:0]        wb_pc_out,
    output logic [ENTRY_W-1:0] wb_entry_out,
    output logic               overflow_err_out
);
    localparam int NSRC = 3;
    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;
    localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

    logic [31:0]        alu_res_mem [DEPTH];
    logic [31:0]        alu_pc_mem  [DEPTH];
    logic [31:0]        ld_res_mem  [DEPTH];
    logic [ENTRY_W-1:0] alu_ent_mem [DEPTH];
    logic [ENTRY_W-1:0] ld_ent_mem  [DEPTH];
    logic [ENTRY_W-1:0] st_ent_mem  [DEPTH];

    ptr_t head_q [NSRC];
    ptr_t tail_q [NSRC];
    cnt_t cnt_q  [NSRC];
    logic [1:0] rr_q;

    logic [NSRC-1:0] push_req, full, push_ok, pop;
    logic            found;
    logic [1:0]      win;
    logic [2:0]      idx;
    logic [31:0]        sel_result, sel_pc;
    logic [ENTRY_W-1:0] sel_entry;

    assign push_req = {st_valid_in, ld_valid_in, alu_valid_in};

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            full[i] = (cnt_q[i] == FULL_CNT);
        end
    end

    assign push_ok      = push_req & ~full;
    assign alu_full_out = full[0];
    assign ld_full_out  = full[1];
    assign st_full_out  = full[2];

    // Round-robin search over occupancy as it stood before this edge's pushes
    always_comb begin
        found = 1'b0;
        win   = 2'd0;
        idx   = 3'd0;
        for (int k = 0; k < NSRC; k++) begin
            idx = {1'b0, rr_q} + 3'(k);
            if (idx >= 3'd3) idx = idx - 3'd3;
            if (!found && cnt_q[idx[1:0]] != '0) begin
                found = 1'b1;
                win   = idx[1:0];
            end
        end
    end

    always_comb begin
        pop = '0;
        if (found) pop[win] = 1'b1;
    end

    always_comb begin
        sel_result = '0;
        sel_pc     = '0;
        sel_entry  = '0;
        case (win)
            2'd0: begin
                sel_result = alu_res_mem[head_q[0]];
                sel_pc     = alu_pc_mem[head_q[0]];
                sel_entry  = alu_ent_mem[head_q[0]];
            end
            2'd1: begin
                sel_result = ld_res_mem[head_q[1]];
                sel_entry  = ld_ent_mem[head_q[1]];
            end
            default: sel_entry = st_ent_mem[head_q[2]];
        endcase
    end

    // Payload storage needs no reset; validity lives entirely in the counts
    always_ff @(posedge clk_in) begin
        if (rdy_in && !flush_in) begin
            if (push_ok[0]) begin
                alu_res_mem[tail_q[0]] <= alu_result_in;
                alu_pc_mem[tail_q[0]]  <= alu_pc_in;
                alu_ent_mem[tail_q[0]] <= alu_entry_in;
            end
            if (push_ok[1]) begin
                ld_res_mem[tail_q[1]] <= ld_result_in;
                ld_ent_mem[tail_q[1]] <= ld_entry_in;
            end
            if (push_ok[2]) st_ent_mem[tail_q[2]] <= st_entry_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NSRC; i++) begin
                head_q[i] <= '0;
                tail_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            rr_q             <= 2'd0;
            wb_valid_out     <= 1'b0;
            wb_src_out       <= 2'd0;
            wb_result_out    <= '0;
            wb_pc_out        <= '0;
            wb_entry_out     <= '0;
            overflow_err_out <= 1'b0;
        end else if (flush_in) begin
            for (int i = 0; i < NSRC; i++) begin
                head_q[i] <= '0;
                tail_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            rr_q         <= 2'd0;
            wb_valid_out <= 1'b0;
        end else if (rdy_in) begin
            for (int i = 0; i < NSRC; i++) begin
                if (push_ok[i]) tail_q[i] <= tail_q[i] + ptr_t'(1);
                if (pop[i])     head_q[i] <= head_q[i] + ptr_t'(1);
                cnt_q[i] <= cnt_q[i] + cnt_t'(push_ok[i]) - cnt_t'(pop[i]);
            end
            // A push into a full FIFO is lost even if that FIFO pops this edge
            if (|(push_req & full)) overflow_err_out <= 1'b1;
            if (found) begin
                wb_valid_out  <= 1'b1;
                wb_src_out    <= win;
                wb_result_out <= sel_result;
                wb_pc_out     <= sel_pc;
                wb_entry_out  <= sel_entry;
                rr_q          <= (win == 2'd2) ? 2'd0 : win + 2'd1;
            end else begin
                wb_valid_out <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter: latency, round-robin order, overflow,
// flush, pause and asynchronous reset.
module tb_wb_bus_arbiter;
    logic        clk_in = 1'b0;
    logic        rst_n_in, rdy_in, flush_in;
    logic        alu_valid_in, ld_valid_in, st_valid_in;
    logic [31:0] alu_result_in, alu_pc_in, ld_result_in;
    logic [3:0]  alu_entry_in, ld_entry_in, st_entry_in;
    logic        alu_full_out, ld_full_out, st_full_out;
    logic        wb_valid_out, overflow_err_out;
    logic [1:0]  wb_src_out;
    logic [31:0] wb_result_out, wb_pc_out;
    logic [3:0]  wb_entry_out;

    int total = 0;
    int bad   = 0;

    wb_bus_arbiter #(.DEPTH(4), .PTR_W(2), .ENTRY_W(4)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .alu_valid_in(alu_valid_in), .alu_result_in(alu_result_in),
        .alu_pc_in(alu_pc_in), .alu_entry_in(alu_entry_in),
        .ld_valid_in(ld_valid_in), .ld_result_in(ld_result_in), .ld_entry_in(ld_entry_in),
        .st_valid_in(st_valid_in), .st_entry_in(st_entry_in),
        .alu_full_out(alu_full_out), .ld_full_out(ld_full_out), .st_full_out(st_full_out),
        .wb_valid_out(wb_valid_out), .wb_src_out(wb_src_out),
        .wb_result_out(wb_result_out), .wb_pc_out(wb_pc_out),
        .wb_entry_out(wb_entry_out), .overflow_err_out(overflow_err_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic beat(input string tag, input logic [1:0] src, input logic [3:0] ent,
                        input logic [31:0] res, input logic [31:0] pc);
        chk({tag, "_valid"}, 32'(wb_valid_out), 32'd1);
        chk({tag, "_src"}, 32'(wb_src_out), 32'(src));
        chk({tag, "_entry"}, 32'(wb_entry_out), 32'(ent));
        chk({tag, "_result"}, wb_result_out, res);
        chk({tag, "_pc"}, wb_pc_out, pc);
    endtask

    task automatic clear_pushes();
        alu_valid_in = 1'b0;
        ld_valid_in  = 1'b0;
        st_valid_in  = 1'b0;
    endtask

    // Expected bus after each edge of the ld-fill sequence (ALU e0..e5, LOAD e8..e14)
    int exp_v   [14] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int exp_src [14] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    int exp_ent [14] = '{0, 0, 8, 1, 9, 2, 10, 3, 11, 4, 12, 5, 13, 0};

    initial begin
        rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
        clear_pushes();
        alu_result_in = '0; alu_pc_in = '0; alu_entry_in = '0;
        ld_result_in = '0; ld_entry_in = '0; st_entry_in = '0;
        step();
        step();
        chk("rst_valid", 32'(wb_valid_out), 32'd0);
        chk("rst_fulls", 32'({alu_full_out, ld_full_out, st_full_out}), 32'd0);
        chk("rst_ovf", 32'(overflow_err_out), 32'd0);
        chk("rst_result", wb_result_out, 32'd0);
        rst_n_in = 1'b1;

        // single ALU push: beat appears after the second edge
        alu_valid_in = 1'b1; alu_result_in = 32'h11; alu_pc_in = 32'h40; alu_entry_in = 4'd3;
        step();
        clear_pushes();
        chk("t1_lat_valid", 32'(wb_valid_out), 32'd0);
        step();
        beat("t1", 2'd0, 4'd3, 32'h11, 32'h40);
        step();
        chk("t1_idle", 32'(wb_valid_out), 32'd0);

        // flush to return rr to 0, then all three sources at once
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        alu_valid_in = 1'b1; alu_result_in = 32'hA1; alu_pc_in = 32'hB1; alu_entry_in = 4'd1;
        ld_valid_in = 1'b1; ld_result_in = 32'hA2; ld_entry_in = 4'd2;
        st_valid_in = 1'b1; st_entry_in = 4'd3;
        step();
        clear_pushes();
        step();
        beat("t2_alu", 2'd0, 4'd1, 32'hA1, 32'hB1);
        step();
        beat("t2_ld", 2'd1, 4'd2, 32'hA2, 32'h0);
        step();
        beat("t2_st", 2'd2, 4'd3, 32'h0, 32'h0);
        step();
        chk("t2_idle", 32'(wb_valid_out), 32'd0);

        // load FIFO fills while ALU competes for the bus; push at c=6 hits a full FIFO
        for (int c = 0; c < 14; c++) begin
            alu_valid_in  = (c <= 5);
            alu_entry_in  = 4'(c);
            alu_result_in = 32'h100 + 32'(c);
            alu_pc_in     = 32'h300 + 32'(c);
            ld_valid_in   = (c <= 6);
            ld_entry_in   = 4'(8 + c);
            ld_result_in  = 32'h200 + 32'(c);
            step();
            chk($sformatf("t3_valid_%0d", c), 32'(wb_valid_out), 32'(exp_v[c]));
            if (exp_v[c] == 1) begin
                chk($sformatf("t3_src_%0d", c), 32'(wb_src_out), 32'(exp_src[c]));
                chk($sformatf("t3_entry_%0d", c), 32'(wb_entry_out), 32'(exp_ent[c]));
                if (exp_src[c] == 0) begin
                    chk($sformatf("t3_res_%0d", c), wb_result_out, 32'h100 + 32'(exp_ent[c]));
                    chk($sformatf("t3_pc_%0d", c), wb_pc_out, 32'h300 + 32'(exp_ent[c]));
                end else begin
                    chk($sformatf("t3_res_%0d", c), wb_result_out, 32'h200 + 32'(exp_ent[c] - 8));
                    chk($sformatf("t3_pc_%0d", c), wb_pc_out, 32'h0);
                end
            end
            if (c == 4) chk("t3_ldfull_pre", 32'(ld_full_out), 32'd0);
            if (c == 5) begin
                chk("t3_ldfull", 32'(ld_full_out), 32'd1);
                chk("t3_ovf_pre", 32'(overflow_err_out), 32'd0);
            end
            if (c == 6) begin
                chk("t3_ovf", 32'(overflow_err_out), 32'd1);
                chk("t3_ldfull_post", 32'(ld_full_out), 32'd0);
            end
        end
        clear_pushes();

        // flush with pending entries and a same-cycle ALU push
        alu_valid_in = 1'b1; alu_result_in = 32'hC1; alu_pc_in = 32'hD1; alu_entry_in = 4'd1;
        ld_valid_in = 1'b1; ld_result_in = 32'hC2; ld_entry_in = 4'd2;
        st_valid_in = 1'b1; st_entry_in = 4'd3;
        step();
        clear_pushes();
        flush_in = 1'b1;
        alu_valid_in = 1'b1; alu_entry_in = 4'd9;
        step();
        flush_in = 1'b0;
        clear_pushes();
        chk("t4_valid", 32'(wb_valid_out), 32'd0);
        chk("t4_fulls", 32'({alu_full_out, ld_full_out, st_full_out}), 32'd0);
        chk("t4_ovf_kept", 32'(overflow_err_out), 32'd1);
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("t4_quiet_%0d", c), 32'(wb_valid_out), 32'd0);
        end

        // pause mid-drain; pushes during the pause are ignored
        alu_valid_in = 1'b1; alu_result_in = 32'h44; alu_pc_in = 32'h54; alu_entry_in = 4'd4;
        ld_valid_in = 1'b1; ld_result_in = 32'h55; ld_entry_in = 4'd5;
        st_valid_in = 1'b1; st_entry_in = 4'd6;
        step();
        clear_pushes();
        step();
        beat("t5_alu", 2'd0, 4'd4, 32'h44, 32'h54);
        rdy_in = 1'b0;
        alu_valid_in = 1'b1; alu_result_in = 32'hEE; alu_entry_in = 4'd15;
        for (int c = 0; c < 3; c++) begin
            step();
            beat($sformatf("t5_hold%0d", c), 2'd0, 4'd4, 32'h44, 32'h54);
        end
        clear_pushes();
        rdy_in = 1'b1;
        step();
        beat("t5_ld", 2'd1, 4'd5, 32'h55, 32'h0);
        step();
        beat("t5_st", 2'd2, 4'd6, 32'h0, 32'h0);
        step();
        chk("t5_idle", 32'(wb_valid_out), 32'd0);

        // asynchronous reset mid-cycle with a load still queued
        alu_valid_in = 1'b1; alu_result_in = 32'h77; alu_pc_in = 32'h87; alu_entry_in = 4'd7;
        ld_valid_in = 1'b1; ld_result_in = 32'h88; ld_entry_in = 4'd8;
        step();
        clear_pushes();
        step();
        beat("t6_pre", 2'd0, 4'd7, 32'h77, 32'h87);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("t6_valid", 32'(wb_valid_out), 32'd0);
        chk("t6_entry", 32'(wb_entry_out), 32'd0);
        chk("t6_result", wb_result_out, 32'd0);
        chk("t6_pc", wb_pc_out, 32'd0);
        chk("t6_ovf", 32'(overflow_err_out), 32'd0);
        step();
        rst_n_in = 1'b1;
        step();
        step();
        chk("t6_post_valid", 32'(wb_valid_out), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
